// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states and the
// {gt, eq, lt} one-hot result encoding.
package serial_cmp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EQ     = 3'd1,
        ST_GT     = 3'd2,
        ST_LT     = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    // Bit order matches the output ports {x, y, z} = {a>b, a==b, a<b}.
    typedef logic [2:0] cmp_res_t;

    localparam cmp_res_t RES_NONE = 3'b000;
    localparam cmp_res_t RES_GT   = 3'b100;
    localparam cmp_res_t RES_EQ   = 3'b010;
    localparam cmp_res_t RES_LT   = 3'b001;

    function automatic state_t decide(input logic a, input logic b);
        if (a && !b) begin
            return ST_GT;
        end else if (!a && b) begin
            return ST_LT;
        end
        return ST_EQ;
    endfunction

    function automatic cmp_res_t res_of(input state_t s);
        case (s)
            ST_GT:   return RES_GT;
            ST_LT:   return RES_LT;
            ST_EQ:   return RES_EQ;
            default: return RES_NONE;
        endcase
    endfunction

endpackage

// File: rtl/serial_cmp_counter.sv
// Saturating beat counter. Clear and increment together load 1, which is how
// a frame's first beat is counted.
module serial_cmp_counter #(
    parameter int MAX_LEN = 16,
    parameter int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          incr,
    output logic [CW-1:0] count
);

    // MAX_LEN+1 may not fit when it is a power of two; clip to all-ones then.
    localparam int            CAP_RAW = MAX_LEN + 1;
    localparam logic [CW-1:0] CAP     = (CAP_RAW > (2 ** CW) - 1) ? {CW{1'b1}} : CW'(CAP_RAW);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= incr ? CW'(1) : '0;
        end else if (incr && (count != CAP)) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator with valid/ready beat input and a
// held result that blocks new frames until consumed.
//
//   state     | meaning
//   ----------|----------------------------------------------------------
//   ST_IDLE   | waiting for a beat with in_first; other beats are dropped
//   ST_EQ     | all bits so far equal, still undecided
//   ST_GT     | decided a > b, remaining bits only counted
//   ST_LT     | decided a < b, remaining bits only counted
//   ST_RESULT | result or length error held until out_ready
module serial_mag_comparator
    import serial_cmp_pkg::*;
#(
    parameter int MAX_LEN = 16,
    localparam int CW     = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_first,
    input  logic          in_last,
    input  logic          a,
    input  logic          b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          x,
    output logic          y,
    output logic          z,
    output logic          len_err,
    output logic [CW-1:0] bit_count
);

    state_t   state;
    state_t   upd;
    cmp_res_t res;
    logic     beat;
    logic     len_over;
    logic     cnt_clr;
    logic     cnt_incr;

    assign beat     = in_valid && in_ready;
    assign len_over = (bit_count == CW'(MAX_LEN));
    assign {x, y, z} = res;

    // A new MSB always re-decides; once GT/LT is reached later bits are ignored.
    always_comb begin
        if (in_first || (state == ST_IDLE) || (state == ST_EQ)) begin
            upd = decide(a, b);
        end else begin
            upd = state;
        end
    end

    always_comb begin
        cnt_clr  = 1'b0;
        cnt_incr = 1'b0;
        case (state)
            ST_IDLE: begin
                if (beat && in_first) begin
                    cnt_clr  = 1'b1;
                    cnt_incr = 1'b1;
                end
            end
            ST_EQ, ST_GT, ST_LT: begin
                if (beat) begin
                    cnt_clr  = in_first;
                    cnt_incr = 1'b1;
                end
            end
            ST_RESULT: cnt_clr = out_ready;
            default:   cnt_clr = 1'b1;
        endcase
    end

    serial_cmp_counter #(
        .MAX_LEN (MAX_LEN),
        .CW      (CW)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .incr  (cnt_incr),
        .count (bit_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            res       <= RES_NONE;
            len_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_EQ, ST_GT, ST_LT: begin
                    in_ready <= 1'b1;
                    if (beat && (in_first || (state != ST_IDLE))) begin
                        if (in_last) begin
                            state     <= ST_RESULT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            res       <= res_of(upd);
                            len_err   <= 1'b0;
                        end else if (!in_first && len_over) begin
                            // Overlong frame: this beat's bits are not compared.
                            state     <= ST_RESULT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            res       <= RES_NONE;
                            len_err   <= 1'b1;
                        end else begin
                            state <= upd;
                        end
                    end
                end
                ST_RESULT: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        res       <= RES_NONE;
                        len_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    res       <= RES_NONE;
                    len_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator: hand-computed frames, back-pressure,
// length error, restart and mid-frame reset.
module tb_serial_mag_comparator;
    import serial_cmp_pkg::*;

    localparam int MAX_LEN = 16;
    localparam int CW      = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_first;
    logic          in_last;
    logic          a;
    logic          b;
    logic          out_valid;
    logic          out_ready;
    logic          x;
    logic          y;
    logic          z;
    logic          len_err;
    logic [CW-1:0] bit_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_mag_comparator #(.MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .y         (y),
        .z         (z),
        .len_err   (len_err),
        .bit_count (bit_count)
    );

    // Offer one beat at the falling edge; return just after the next rising edge.
    task automatic drive(input logic va, input logic vb, input logic f, input logic l);
        @(negedge clk);
        in_valid = 1'b1; a = va; b = vb; in_first = f; in_last = l;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        @(negedge clk);
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; a = 1'b0; b = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] av, input logic [63:0] bv, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            drive(av[i], bv[i], i == n - 1, i == 0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        tests++; if ({x, y, z} !== 3'b000) begin fails++; $display("FAIL rst_xyz: got %b want 000", {x, y, z}); end
        tests++; if (len_err !== 1'b0) begin fails++; $display("FAIL rst_len_err: got %b want 0", len_err); end
        tests++; if (bit_count !== '0) begin fails++; $display("FAIL rst_bit_count: got %0d want 0", bit_count); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_equal();
        logic [7:0] av;
        logic [7:0] bv;
        av = 8'hA5;
        bv = 8'hA5;
        out_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            drive(av[i], bv[i], i == 7, i == 0);
            if (i == 1) begin
                tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL eq_early_valid: got %b want 0", out_valid); end
            end
        end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL eq_valid: got %b want 1", out_valid); end
        tests++; if ({x, y, z} !== 3'b010) begin fails++; $display("FAIL eq_xyz: got %b want 010", {x, y, z}); end
        tests++; if (bit_count !== CW'(8)) begin fails++; $display("FAIL eq_bit_count: got %0d want 8", bit_count); end
        tests++; if (len_err !== 1'b0) begin fails++; $display("FAIL eq_len_err: got %b want 0", len_err); end
        quiet();
        @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL eq_one_cycle: got %b want 0", out_valid); end
        tests++; if ({x, y, z} !== 3'b000) begin fails++; $display("FAIL eq_xyz_cleared: got %b want 000", {x, y, z}); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL eq_in_ready_after: got %b want 1", in_ready); end
    endtask

    task automatic test_decide_points();
        logic [7:0] av;
        logic [7:0] bv;
        out_ready = 1'b1;
        av = 8'h80;
        bv = 8'h7F;
        for (int i = 7; i >= 0; i--) begin
            drive(av[i], bv[i], i == 7, i == 0);
            if (i == 7) begin
                tests++; if (dut.state !== ST_GT) begin fails++; $display("FAIL gt_beat1_state: got %0d want %0d", dut.state, ST_GT); end
            end
        end
        tests++; if ({x, y, z} !== 3'b100) begin fails++; $display("FAIL gt_xyz: got %b want 100", {x, y, z}); end
        tests++; if (bit_count !== CW'(8)) begin fails++; $display("FAIL gt_bit_count: got %0d want 8", bit_count); end
        quiet();
        @(posedge clk);
        #1;
        av = 8'h3C;
        bv = 8'h3D;
        for (int i = 7; i >= 0; i--) begin
            drive(av[i], bv[i], i == 7, i == 0);
            if (i == 1) begin
                tests++; if (dut.state !== ST_EQ) begin fails++; $display("FAIL lt_beat7_state: got %0d want %0d", dut.state, ST_EQ); end
            end
        end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL lt_valid: got %b want 1", out_valid); end
        tests++; if ({x, y, z} !== 3'b001) begin fails++; $display("FAIL lt_xyz: got %b want 001", {x, y, z}); end
        quiet();
        @(posedge clk);
        #1;
    endtask

    task automatic test_one_bit();
        logic [2:0] va;
        logic [2:0] vb;
        logic [2:0] exp_res [3];
        va = 3'b100;
        vb = 3'b001;
        exp_res[0] = 3'b100;
        exp_res[1] = 3'b010;
        exp_res[2] = 3'b001;
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tests++; if (bit_count !== '0) begin fails++; $display("FAIL drop_bit_count: got %0d want 0", bit_count); end
        tests++; if (dut.state !== ST_IDLE) begin fails++; $display("FAIL drop_state: got %0d want %0d", dut.state, ST_IDLE); end
        for (int k = 0; k < 3; k++) begin
            drive(va[2 - k], vb[2 - k], 1'b1, 1'b1);
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bit1_valid[%0d]: got %b want 1", k, out_valid); end
            tests++; if ({x, y, z} !== exp_res[k]) begin fails++; $display("FAIL bit1_xyz[%0d]: got %b want %b", k, {x, y, z}, exp_res[k]); end
            tests++; if (bit_count !== CW'(1)) begin fails++; $display("FAIL bit1_count[%0d]: got %0d want 1", k, bit_count); end
            quiet();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_frame(64'h12, 64'h34, 8);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b want 1", out_valid); end
        @(negedge clk);
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; a = 1'b1; b = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", c, out_valid); end
            tests++; if ({x, y, z} !== 3'b001) begin fails++; $display("FAIL bp_hold_xyz[%0d]: got %b want 001", c, {x, y, z}); end
            tests++; if (bit_count !== CW'(8)) begin fails++; $display("FAIL bp_hold_count[%0d]: got %0d want 8", c, bit_count); end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_in_ready[%0d]: got %b want 0", c, in_ready); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        tests++; if (dut.state !== ST_IDLE) begin fails++; $display("FAIL bp_release_state: got %0d want %0d", dut.state, ST_IDLE); end
        tests++; if (bit_count !== '0) begin fails++; $display("FAIL bp_no_accept_count: got %0d want 0", bit_count); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        quiet();
        @(posedge clk);
        #1;
    endtask

    task automatic test_len_err_restart();
        out_ready = 1'b1;
        for (int i = 1; i <= MAX_LEN + 1; i++) begin
            drive(1'b1, 1'b1, i == 1, 1'b0);
            if (i == MAX_LEN) begin
                tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL len_at_max_valid: got %b want 0", out_valid); end
                tests++; if (bit_count !== CW'(MAX_LEN)) begin fails++; $display("FAIL len_at_max_count: got %0d want %0d", bit_count, MAX_LEN); end
            end
        end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL len_valid: got %b want 1", out_valid); end
        tests++; if (len_err !== 1'b1) begin fails++; $display("FAIL len_err: got %b want 1", len_err); end
        tests++; if ({x, y, z} !== 3'b000) begin fails++; $display("FAIL len_xyz: got %b want 000", {x, y, z}); end
        tests++; if (bit_count !== CW'(17)) begin fails++; $display("FAIL len_bit_count: got %0d want 17", bit_count); end
        quiet();
        @(posedge clk);
        #1;
        tests++; if (len_err !== 1'b0) begin fails++; $display("FAIL len_err_cleared: got %b want 0", len_err); end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (dut.state !== ST_GT) begin fails++; $display("FAIL rs_partial_state: got %0d want %0d", dut.state, ST_GT); end
        tests++; if (bit_count !== CW'(3)) begin fails++; $display("FAIL rs_partial_count: got %0d want 3", bit_count); end
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rs_no_result: got %b want 0", out_valid); end
        tests++; if (bit_count !== CW'(1)) begin fails++; $display("FAIL rs_restart_count: got %0d want 1", bit_count); end
        tests++; if (dut.state !== ST_LT) begin fails++; $display("FAIL rs_restart_state: got %0d want %0d", dut.state, ST_LT); end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tests++; if ({x, y, z} !== 3'b001) begin fails++; $display("FAIL rs_xyz: got %b want 001", {x, y, z}); end
        tests++; if (bit_count !== CW'(2)) begin fails++; $display("FAIL rs_bit_count: got %0d want 2", bit_count); end
        quiet();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] av;
        logic [7:0] bv;
        av = 8'hF0;
        bv = 8'h0F;
        out_ready = 1'b1;
        for (int i = 7; i >= 5; i--) begin
            drive(av[i], bv[i], i == 7, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b1; a = av[4]; b = bv[4]; in_first = 1'b0; in_last = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mrst_valid: got %b want 0", out_valid); end
        tests++; if ({x, y, z, len_err} !== 4'b0000) begin fails++; $display("FAIL mrst_flags: got %b want 0000", {x, y, z, len_err}); end
        tests++; if (bit_count !== '0) begin fails++; $display("FAIL mrst_bit_count: got %0d want 0", bit_count); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mrst_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mrst_release_ready: got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mrst_no_pulse: got %b want 0", out_valid); end
        send_frame(64'h0F, 64'h0E, 8);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mrst_fresh_valid: got %b want 1", out_valid); end
        tests++; if ({x, y, z} !== 3'b100) begin fails++; $display("FAIL mrst_fresh_xyz: got %b want 100", {x, y, z}); end
        tests++; if (bit_count !== CW'(8)) begin fails++; $display("FAIL mrst_fresh_count: got %0d want 8", bit_count); end
        quiet();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_equal();
        test_decide_points();
        test_one_bit();
        test_backpressure();
        test_len_err_restart();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
